// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline write-back path always
// owns the port; late writes (mul/div, delayed loads) are queued in a small FIFO
// and drained only in cycles the pipeline leaves the port idle. Publishes a
// pending-destination mask for the ID interlock and a starvation stall request.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        p_write_data_in,
  input  logic [ADDR_W-1:0]        p_rd_addr_in,
  input  logic                     p_reg_write_in,
  input  logic                     l_valid_in,
  output logic                     l_ready_out,
  input  logic [DATA_W-1:0]        l_data_in,
  input  logic [ADDR_W-1:0]        l_rd_addr_in,
  output logic [DATA_W-1:0]        rf_write_data_out,
  output logic [ADDR_W-1:0]        rf_rd_addr_out,
  output logic                     rf_write_en_out,
  output logic [31:0]              pend_mask_out,
  output logic                     stall_req_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // FIFO storage is read combinationally at the head so a queued entry can
  // use an idle port in the very cycle it is at the front.
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg, valid_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [STV_W-1:0]  starve_reg, starve_next;
  logic              stall_reg, stall_next;

  logic p_pipe, pop, push, enq;
  logic [31:0] entry_mask [DEPTH];

  // Handshake and arbitration decisions; everything is suppressed in reset.
  always_comb begin
    p_pipe      = p_reg_write_in && (p_rd_addr_in != '0);
    pop         = rst && !p_pipe && (count_reg != '0);
    l_ready_out = rst && (count_reg < CNT_W'(DEPTH));
    push        = l_valid_in && l_ready_out;
    // Writes to x0 complete the handshake but are dropped.
    enq         = push && (l_rd_addr_in != '0);
  end

  // Port mux: pipeline first, then FIFO head, otherwise idle with zeroed bus.
  always_comb begin
    rf_write_en_out   = 1'b0;
    rf_rd_addr_out    = '0;
    rf_write_data_out = '0;
    if (rst) begin
      if (p_pipe) begin
        rf_write_en_out   = 1'b1;
        rf_rd_addr_out    = p_rd_addr_in;
        rf_write_data_out = p_write_data_in;
      end else if (count_reg != '0) begin
        rf_write_en_out   = 1'b1;
        rf_rd_addr_out    = addr_mem[rd_ptr_reg];
        rf_write_data_out = data_mem[rd_ptr_reg];
      end
    end
  end

  // Per-entry one-hot destination decode, masked by the slot's valid bit.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
      assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
    end
  endgenerate

  // Pending mask is the OR of every queued destination.
  always_comb begin
    pend_mask_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask_out = pend_mask_out | entry_mask[i];
    end
    if (!rst) pend_mask_out = '0;
  end

  // Next-state for occupancy, slot valid bits and starvation tracking.
  always_comb begin
    valid_next = valid_reg;
    if (pop) valid_next[rd_ptr_reg] = 1'b0;
    if (enq) valid_next[wr_ptr_reg] = 1'b1;

    count_next = count_reg;
    if (enq && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!enq && pop) count_next = count_reg - CNT_W'(1);

    starve_next = starve_reg;
    if (pop || (count_reg == '0))                  starve_next = '0;
    else if (starve_reg != STV_W'(STARVE_LIMIT))   starve_next = starve_reg + STV_W'(1);

    stall_next = stall_reg;
    if (pop)                                       stall_next = 1'b0;
    else if (starve_next == STV_W'(STARVE_LIMIT))  stall_next = 1'b1;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      starve_reg <= starve_next;
      stall_reg  <= stall_next;
    end
  end

  // Payload storage; contents are meaningless unless the slot is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wr_ptr_reg] <= l_data_in;
      addr_mem[wr_ptr_reg] <= l_rd_addr_in;
    end
  end

  assign stall_req_out  = stall_reg;
  assign fifo_count_out = count_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p_write_data_in;
  logic [4:0]  p_rd_addr_in;
  logic        p_reg_write_in;
  logic        l_valid_in;
  logic        l_ready_out;
  logic [31:0] l_data_in;
  logic [4:0]  l_rd_addr_in;
  logic [31:0] rf_write_data_out;
  logic [4:0]  rf_rd_addr_out;
  logic        rf_write_en_out;
  logic [31:0] pend_mask_out;
  logic        stall_req_out;
  logic [2:0]  fifo_count_out;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_W(32), .ADDR_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .p_write_data_in  (p_write_data_in),
    .p_rd_addr_in     (p_rd_addr_in),
    .p_reg_write_in   (p_reg_write_in),
    .l_valid_in       (l_valid_in),
    .l_ready_out      (l_ready_out),
    .l_data_in        (l_data_in),
    .l_rd_addr_in     (l_rd_addr_in),
    .rf_write_data_out(rf_write_data_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_write_en_out  (rf_write_en_out),
    .pend_mask_out    (pend_mask_out),
    .stall_req_out    (stall_req_out),
    .fifo_count_out   (fifo_count_out)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  bit   checks_on = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic r, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld, output bit acc);
    logic [31:0] mask;
    bit pipe, pop, push;
    rst = r; p_reg_write_in = pw; p_rd_addr_in = pa; p_write_data_in = pd;
    l_valid_in = lv; l_rd_addr_in = la; l_data_in = ld;
    #1;
    pipe = pw && (pa != 5'd0);
    mask = 32'd0;
    foreach (q[i]) mask = mask | (32'd1 << q[i].a);
    push = r && lv && (q.size() < DEPTH);
    pop  = r && !pipe && (q.size() > 0);
    if (checks_on) begin
      chk("count", 32'(fifo_count_out), 32'(q.size()));
      chk("stall", 32'(stall_req_out), 32'(starve >= LIMIT));
      if (!r) begin
        chk("ready_in_reset", 32'(l_ready_out), 32'd0);
        chk("wen_in_reset", 32'(rf_write_en_out), 32'd0);
        chk("pend_in_reset", pend_mask_out, 32'd0);
      end else begin
        chk("ready", 32'(l_ready_out), 32'(q.size() < DEPTH));
        chk("pend", pend_mask_out, mask);
        if (pipe) begin
          chk("wen_pipe", 32'(rf_write_en_out), 32'd1);
          chk("addr_pipe", 32'(rf_rd_addr_out), 32'(pa));
          chk("data_pipe", rf_write_data_out, pd);
        end else if (q.size() > 0) begin
          chk("wen_late", 32'(rf_write_en_out), 32'd1);
          chk("addr_late", 32'(rf_rd_addr_out), 32'(q[0].a));
          chk("data_late", rf_write_data_out, q[0].d);
        end else begin
          chk("wen_idle", 32'(rf_write_en_out), 32'd0);
          chk("addr_idle", 32'(rf_rd_addr_out), 32'd0);
          chk("data_idle", rf_write_data_out, 32'd0);
        end
      end
    end
    @(posedge clk);
    acc = push;
    if (!r) begin
      q.delete();
      starve = 0;
    end else begin
      if (pop || q.size() == 0) starve = 0;
      else if (starve < LIMIT) starve++;
      if (pop) void'(q.pop_front());
      if (push && la != 5'd0) q.push_back('{a: la, d: ld});
    end
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int idx;
    rst = 1'b0; p_reg_write_in = 1'b0; p_rd_addr_in = '0; p_write_data_in = '0;
    l_valid_in = 1'b0; l_rd_addr_in = '0; l_data_in = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    checks_on = 1;

    // Reset mid-operation with three entries queued behind a busy pipeline.
    for (int c = 0; c < 3; c++) step(1, 1, 9, 32'h900 + c, 1, 5'(3 + c), 32'hA00 + c, acc);
    chk("pre_reset_count", 32'(fifo_count_out), 32'd3);
    step(0, 1, 9, 32'h999, 1, 6, 32'hB00, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);

    // Idle pipeline: accepted entry writes the port the following cycle.
    step(1, 0, 0, 0, 1, 7, 32'hDEADBEEF, acc);
    chk("idle_accept", 32'(acc), 32'd1);
    chk("idle_wen", 32'(rf_write_en_out), 32'd1);
    chk("idle_addr", 32'(rf_rd_addr_out), 32'd7);
    chk("idle_data", rf_write_data_out, 32'hDEADBEEF);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    chk("idle_drained", 32'(fifo_count_out), 32'd0);

    // Fill while the pipeline owns the port, then drain in order.
    idx = 1;
    for (int c = 0; c < 6; c++) begin
      step(1, 1, 10, 32'hC00 + c, idx <= 5, 5'(idx), 32'h100 + idx, acc);
      if (acc) idx++;
    end
    chk("fill_count", 32'(fifo_count_out), 32'd4);
    chk("fill_ready", 32'(l_ready_out), 32'd0);
    chk("fill_pend", pend_mask_out, 32'h0000001E);
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0, 0, idx <= 5, 5'(idx), 32'h100 + idx, acc);
      if (acc) idx++;
    end

    // Starvation: one entry held off by continuous pipeline writes.
    step(1, 1, 11, 32'hD00, 1, 12, 32'hE00, acc);
    for (int c = 0; c < LIMIT; c++) step(1, 1, 11, 32'hD01 + c, 0, 0, 0, acc);
    chk("stall_set", 32'(stall_req_out), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    chk("stall_clr", 32'(stall_req_out), 32'd0);

    // x0 handling on both requesters.
    step(1, 1, 11, 32'hD10, 1, 13, 32'hE10, acc);
    step(1, 1, 0, 32'hD11, 0, 0, 0, acc);
    step(1, 1, 14, 32'hD12, 1, 0, 32'hE12, acc);
    chk("x0_late_accept", 32'(acc), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, acc);

    // Simultaneous push/pop at count 2, long enough to wrap the pointers.
    step(1, 1, 15, 32'hD20, 1, 16, 32'hF00, acc);
    step(1, 1, 15, 32'hD21, 1, 17, 32'hF01, acc);
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 0, 0, 1, 5'(18 + c), 32'hF02 + c, acc);
      chk("pushpop_count", 32'(fifo_count_out), 32'd2);
    end
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0, 0, 0, 0, acc);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
